// File: rtl/sff_bank_readback_if.sv
// Serial readback stream: one data bit per transfer, with valid/ready handshake and an end-of-frame marker.
interface sff_bank_readback_if;
  logic sdo;
  logic sdo_valid;
  logic sdo_ready;
  logic sdo_last;

  modport master (output sdo, output sdo_valid, output sdo_last, input sdo_ready);
  modport slave  (input sdo, input sdo_valid, input sdo_last, output sdo_ready);
endinterface

// File: rtl/sff_bank_readback.sv
// Snapshots a bank of flop outputs and shifts it out MSB first over a valid/ready stream.
// Optional feature macro: SFF_READBACK_PARITY_EN appends an even-parity bit to each frame.
module sff_bank_readback #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_req,
  input  logic [WIDTH-1:0]     q_bus,
  sff_bank_readback_if.master  sdo_if,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SFF_READBACK_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [FRAME-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             valid_q, valid_nxt;
  logic             last_q, last_nxt;
  logic             busy_nxt, done_nxt;
  logic [FRAME-1:0] cap_word;

  // Captured frame: data word, followed by its parity bit when enabled
`ifdef SFF_READBACK_PARITY_EN
  assign cap_word = {q_bus, ^q_bus};
`else
  assign cap_word = q_bus;
`endif

  // Shifted-out positions refill with 0, so sdo reads 0 once the frame has drained
  assign sdo_if.sdo       = shreg[FRAME-1];
  assign sdo_if.sdo_valid = valid_q;
  assign sdo_if.sdo_last  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      valid_q <= valid_nxt;
      last_q  <= last_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cap_req) begin
          shreg_nxt = cap_word;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          last_nxt  = (FRAME == 1);
        end
      end
      SHIFT: begin
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
        last_nxt  = last_q;
        if (sdo_if.sdo_ready) begin
          shreg_nxt = shreg << 1;
          cnt_nxt   = CNT_W'(cnt + 1'b1);
          if (cnt == CNT_W'(FRAME - 1)) begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            last_nxt = (CNT_W'(cnt + 1'b1) == CNT_W'(FRAME - 1));
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sff_bank_readback.sv
// Scoreboard bench for sff_bank_readback: expected frames are queued at capture, a monitor checks each transfer.
module tb_sff_bank_readback;
  localparam int unsigned WIDTH = 8;
`ifdef SFF_READBACK_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  localparam int unsigned FRAME = PARITY ? WIDTH + 1 : WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             cap_req;
  logic [WIDTH-1:0] q_bus;
  logic             busy;
  logic             done;

  sff_bank_readback_if sif ();

  sff_bank_readback #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .cap_req (cap_req),
    .q_bus   (q_bus),
    .sdo_if  (sif),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic d; logic last;} exp_t;
  exp_t exp_q[$];
  int   pending   = 0;
  int   checks    = 0;
  int   errors    = 0;
  bit   last_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference frame: data MSB first, then the even-parity bit when enabled
  task automatic push_frame(input logic [WIDTH-1:0] word);
    exp_t e;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e.d    = word[i];
      e.last = !PARITY && (i == 0);
      exp_q.push_back(e);
    end
    if (PARITY) begin
      e.d    = ^word;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
    pending++;
  endtask

  // Monitor: compares every accepted bit, hold stability, busy and done
  logic prev_hold = 1'b0;
  logic prev_sdo  = 1'b0;
  logic prev_last = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_hold) begin
      chk("hold_valid", sif.sdo_valid, 1);
      chk("hold_sdo", sif.sdo, prev_sdo);
      chk("hold_last", sif.sdo_last, prev_last);
    end
    if (!rst) chk("busy", busy, sif.sdo_valid | done);
    if (!rst && sif.sdo_valid && sif.sdo_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_bit", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sdo", sif.sdo, e.d);
        chk("sdo_last", sif.sdo_last, e.last);
        if (e.last) last_seen = 1'b1;
      end
    end
    if (!rst && done) begin
      chk("done_pulse_width", prev_done, 0);
      chk("done_expected", pending > 0, 1);
      chk("done_after_last", last_seen, 1);
      if (pending > 0) pending--;
      last_seen = 1'b0;
    end
    prev_hold = sif.sdo_valid && !sif.sdo_ready && !rst;
    prev_sdo  = sif.sdo;
    prev_last = sif.sdo_last;
    prev_done = done;
  end

  // Raise cap_req for one cycle from IDLE; q_bus is scrambled right after capture
  task automatic start_frame(input logic [WIDTH-1:0] word, input int mode);
    cap_req       = 1'b1;
    q_bus         = word;
    sif.sdo_ready = (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
    push_frame(word);
    @(posedge clk); #1;
    cap_req = 1'b0;
    q_bus   = WIDTH'($urandom);
    chk("cap_latency", sif.sdo_valid, 1);
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 ready random; noise drives stray cap_req
  task automatic wait_done(input int mode, input bit noise);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (mode == 1)      sif.sdo_ready = ~sif.sdo_ready;
        else if (mode == 2) sif.sdo_ready = 1'($urandom_range(1));
        else                sif.sdo_ready = 1'b1;
        if (noise) begin
          cap_req = ($urandom_range(2) == 0);
          q_bus   = WIDTH'($urandom);
        end
      end
    end
    cap_req = 1'b0;
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    rst           = 1'b1;
    cap_req       = 1'b1;
    q_bus         = 8'hA5;
    sif.sdo_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", sif.sdo_valid, 0);
    chk("rst_sdo", sif.sdo, 0);
    chk("rst_last", sif.sdo_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst     = 1'b0;
    cap_req = 1'b0;
    @(posedge clk); #1;
    chk("no_capture_from_rst", sif.sdo_valid, 0);

    // A5 with ready high: exact done latency
    start_frame(8'hA5, 0);
    repeat (FRAME) @(posedge clk);
    #1;
    chk("done_latency", done, 1);
    chk("done_busy", busy, 1);
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("done_cleared", done, 0);

    // 80 with ready toggling
    start_frame(8'h80, 1);
    wait_done(1, 1'b0);

    // cap_req held through a frame, q_bus changed after capture
    cap_req       = 1'b1;
    q_bus         = 8'h5A;
    sif.sdo_ready = 1'b1;
    push_frame(8'h5A);
    @(posedge clk); #1;
    q_bus = 8'hFF;
    repeat (FRAME) @(posedge clk);
    #1;
    chk("hold_done_latency", done, 1);
    @(posedge clk); #1;
    chk("hold_idle_gap", busy, 0);
    push_frame(8'hFF);
    @(posedge clk); #1;
    chk("hold_next_capture", sif.sdo_valid, 1);
    cap_req = 1'b0;
    wait_done(0, 1'b0);

    // Reset after the third bit of 3C aborts the frame
    start_frame(8'h3C, 0);
    repeat (3) @(posedge clk);
    #1;
    rst           = 1'b1;
    sif.sdo_ready = 1'b0;
    exp_q.delete();
    pending   = 0;
    last_seen = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", sif.sdo_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sdo", sif.sdo, 0);
    rst           = 1'b0;
    sif.sdo_ready = 1'b1;
    repeat (FRAME + 2) @(posedge clk);
    #1;
    start_frame(8'h01, 0);
    wait_done(0, 1'b0);

    if (PARITY) begin
      start_frame(8'h07, 0);
      wait_done(0, 1'b0);
      start_frame(8'h03, 0);
      wait_done(0, 1'b0);
    end

    // Random words, random backpressure, stray cap_req during frames
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      start_frame(WIDTH'($urandom), 2);
      wait_done(2, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    chk("frames_done", pending, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
